// File: rtl/inv_shift_sub_unit_pkg.sv
// Shared AES decrypt-path definitions.
// State geometry, byte indexing and the stage FSM encoding.
package aes_pkg;

  localparam int NB_COLS = 4;
  localparam int NB_ROWS = 4;
  localparam int STATE_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } fsm_t;

  // byte r + 4c, so the column is the upper two index bits
  function automatic logic [3:0] idx(
    input logic [1:0] r,
    input logic [1:0] c
  );
    return {c, r};
  endfunction

endpackage

// File: rtl/inv_shift_sub_unit_if.sv
// Input and output valid/ready channels of the
// InvShiftRows + InvSubBytes stage.
interface inv_shift_sub_unit_if;
  import aes_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] in_state;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] out_state;

  modport master (
    output in_valid,
    output in_state,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_state
  );

  modport slave (
    input  in_valid,
    input  in_state,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_state
  );

endinterface

// File: rtl/inv_shift_sub_unit_sbox.sv
// AES inverse S-box, one byte, purely combinational.
module Inverse_sBox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign o_byte = INV_SBOX[i_byte];

endmodule

// File: rtl/inv_shift_sub_unit.sv
// Iterative InvShiftRows + InvSubBytes, one column per cycle,
// between InvMixColumns of the previous round and AddRoundKey.
module inv_shift_sub_unit
  import aes_pkg::*;
(
  input logic           clk,
  input logic           rst,
  inv_shift_sub_unit_if.slave bus
);

  fsm_t               r_state;
  fsm_t               w_next;
  logic [1:0]         r_col;
  logic [STATE_W-1:0] r_src;
  logic [STATE_W-1:0] r_dst;
  logic               w_accept;
  logic [7:0]         w_sb_in  [NB_ROWS];
  logic [7:0]         w_sb_out [NB_ROWS];

  // row r of output column col comes from source column col - r
  for (genvar r = 0; r < NB_ROWS; r++) begin : g_row
    logic [1:0] w_src_col;
    logic [6:0] w_base;

    assign w_src_col = r_col - 2'(r);
    assign w_base    = {~idx(2'(r), w_src_col), 3'b000};
    assign w_sb_in[r] = r_src[w_base +: 8];

    Inverse_sBox u_sbox (
      .i_byte (w_sb_in[r]),
      .o_byte (w_sb_out[r])
    );
  end

  assign w_accept      = bus.in_valid && (r_state == IDLE);
  assign bus.out_state = r_dst;

  always_comb begin
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (1'b1)
      (r_state == IDLE): begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_next = BUSY;
      end
      (r_state == BUSY): begin
        if (r_col == 2'd3) w_next = DONE;
      end
      (r_state == DONE): begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_col   <= 2'd0;
      r_src   <= '0;
      r_dst   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_src <= bus.in_state;
        r_col <= 2'd0;
      end
      if (r_state == BUSY) begin
        for (int r = 0; r < NB_ROWS; r++) begin
          r_dst[{~idx(2'(r), r_col), 3'b000} +: 8] <= w_sb_out[r];
        end
        if (r_col != 2'd3) r_col <= r_col + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_inv_shift_sub_unit.sv
// Directed bench for the InvShiftRows + InvSubBytes stage.
module tb_inv_shift_sub_unit;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] inv_t [256];

  inv_shift_sub_unit_if bus();

  inv_shift_sub_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
    logic [7:0] v = 8'h00;
    if (a != 8'h00)
      for (int x = 1; x < 256; x++)
        if (gmul(a, 8'(x)) == 8'h01) v = 8'(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
             ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [127:0] o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        int src = r + 4 * ((c - r + 4) % 4);
        int dst = r + 4 * c;
        o[127-8*dst -: 8] = inv_t[s[127-8*src -: 8]];
      end
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] s, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready) begin
        bus.in_valid = 1'b1;
        bus.in_state = s;
        tick();
        bus.in_valid = 1'b0;
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!bus.out_valid) lat = 99;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_state = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      total += 3;
      if (bus.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
      end
      if (bus.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
      end
      if (bus.out_state !== 128'h0) begin
        bad++;
        $display("FAIL reset_out_state got=%h want=0", bus.out_state);
      end
      tick();
    end
  endtask

  task automatic test_zeros();
    bit ok;
    int lat;
    bus.out_ready = 1'b1;
    send({16{8'h63}}, ok);
    wait_out(lat);
    total += 4;
    if (!ok) begin
      bad++;
      $display("FAIL zeros_accept got=%b want=1", ok);
    end
    if (lat != 4) begin
      bad++;
      $display("FAIL zeros_latency got=%0d want=4", lat);
    end
    if (bus.out_state !== 128'h0) begin
      bad++;
      $display("FAIL zeros_state got=%h want=0", bus.out_state);
    end
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL zeros_busy_ready got=%b want=0", bus.in_ready);
    end
    tick();
    total += 2;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL zeros_ov_drop got=%b want=0", bus.out_valid);
    end
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL zeros_ready_back got=%b want=1", bus.in_ready);
    end
  endtask

  task automatic test_vector();
    bit ok;
    int lat;
    logic [127:0] exp_s;
    exp_s = 128'h000d0a07_04010e0b_0805020f_0c090603;
    bus.out_ready = 1'b1;
    send(128'h637c777b_f26b6fc5_3001672b_fed7ab76, ok);
    wait_out(lat);
    total += 2;
    if (lat != 4) begin
      bad++;
      $display("FAIL vec_latency got=%0d want=4", lat);
    end
    if (bus.out_state !== exp_s) begin
      bad++;
      $display("FAIL vec_state got=%h want=%h", bus.out_state, exp_s);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    int seen;
    logic [127:0] exp_s;
    exp_s = 128'h000d0a07_04010e0b_0805020f_0c090603;
    bus.out_ready = 1'b0;
    send(128'h637c777b_f26b6fc5_3001672b_fed7ab76, ok);
    wait_out(lat);
    total++;
    if (lat != 4) begin
      bad++;
      $display("FAIL bp_latency got=%0d want=4", lat);
    end
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_state = {$urandom, $urandom, $urandom, $urandom};
      tick();
      total += 3;
      if (bus.out_valid !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold_valid got=%b want=1", bus.out_valid);
      end
      if (bus.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_in_ready got=%b want=0", bus.in_ready);
      end
      if (bus.out_state !== exp_s) begin
        bad++;
        $display("FAIL bp_stable got=%h want=%h", bus.out_state, exp_s);
      end
    end
    bus.in_state = {16{8'h16}};
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    total += 2;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_xfer got=%b want=0", bus.out_valid);
    end
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_idle_ready got=%b want=1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_second_accept got=%b want=0", bus.in_ready);
    end
    wait_out(lat);
    total += 2;
    if (lat != 4) begin
      bad++;
      $display("FAIL bp2_latency got=%0d want=4", lat);
    end
    if (bus.out_state !== {16{8'hff}}) begin
      bad++;
      $display("FAIL bp2_state got=%h want=%h", bus.out_state, {16{8'hff}});
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL bp_one_xfer got=%0d want=0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] st [8];
    logic [127:0] ex [8];
    int n_in, n_out, cyc, last;
    bit acc;
    for (int i = 0; i < 8; i++) begin
      st[i] = {$urandom, $urandom, $urandom, $urandom};
      ex[i] = model(st[i]);
    end
    n_in = 0;
    n_out = 0;
    cyc = 0;
    last = 0;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_state = st[0];
    while (n_out < 8 && cyc < 200) begin
      acc = bus.in_valid && bus.in_ready;
      tick();
      cyc++;
      if (acc) begin
        n_in++;
        if (n_in < 8) bus.in_state = st[n_in];
        else bus.in_valid = 1'b0;
      end
      if (bus.out_valid) begin
        total++;
        if (bus.out_state !== ex[n_out]) begin
          bad++;
          $display("FAIL b2b_state[%0d] got=%h want=%h",
                   n_out, bus.out_state, ex[n_out]);
        end
        if (n_out > 0) begin
          total++;
          if (cyc - last != 6) begin
            bad++;
            $display("FAIL b2b_gap[%0d] got=%0d want=6", n_out, cyc - last);
          end
        end
        last = cyc;
        n_out++;
      end
    end
    total++;
    if (n_out != 8) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=8", n_out);
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int lat;
    int seen;
    bus.out_ready = 1'b1;
    send({16{8'h63}}, ok);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total += 3;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_ready got=%b want=1", bus.in_ready);
    end
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_valid got=%b want=0", bus.out_valid);
    end
    if (bus.out_state !== 128'h0) begin
      bad++;
      $display("FAIL rstmid_state got=%h want=0", bus.out_state);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL rstmid_no_out got=%0d want=0", seen);
    end
    send({16{8'h16}}, ok);
    wait_out(lat);
    total += 2;
    if (lat != 4) begin
      bad++;
      $display("FAIL rstmid_latency got=%0d want=4", lat);
    end
    if (bus.out_state !== {16{8'hff}}) begin
      bad++;
      $display("FAIL rstmid_out got=%h want=%h", bus.out_state, {16{8'hff}});
    end
    tick();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_state = '0;
    bus.out_ready = 1'b0;
    for (int a = 0; a < 256; a++) inv_t[fwd_sbox(8'(a))] = 8'(a);
    test_reset();
    test_zeros();
    test_vector();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
